// File: rtl/mem_stage_sb_pkg.sv
// Shared types for the memory stage with store buffer: FSM encoding,
// buffered-store entry layout and the default buffer depth.
package mem_stage_sb_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_XLEN          = 32;

    typedef enum logic [1:0] {
        MEM_IDLE    = 2'd0,
        MEM_DRAIN   = 2'd1,
        MEM_LD_WAIT = 2'd2
    } mem_fsm_e;

    typedef struct packed {
        logic [SB_XLEN-1:0] addr;
        logic [SB_XLEN-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/mem_stage_sb_store_buffer.sv
// Circular store FIFO with a parallel word-address search; the youngest
// matching entry supplies forwarded load data.
module mem_stage_sb_store_buffer #(
    parameter int XLEN     = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      push_i,
    input  logic [XLEN-1:0]           push_addr_i,
    input  logic [XLEN-1:0]           push_data_i,
    input  logic                      pop_i,
    output logic [XLEN-1:0]           head_addr_o,
    output logic [XLEN-1:0]           head_data_o,
    input  logic [XLEN-1:0]           lookup_addr_i,
    output logic                      hit_o,
    output logic [XLEN-1:0]           hit_data_o,
    output logic [$clog2(SB_DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_B = PTR_W + 1;

    logic [XLEN-1:0]  addr_q [SB_DEPTH];
    logic [XLEN-1:0]  data_q [SB_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, idx;
    logic [CNT_B-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_B'(1);
                2'b01:   count_q <= count_q - CNT_B'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Walk oldest to youngest so the last match found is the youngest store.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_B'(i) < count_q) &&
                (addr_q[idx][XLEN-1:2] == lookup_addr_i[XLEN-1:2])) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[idx];
            end
        end
    end

    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/mem_stage_sb.sv
// Memory stage: MEM/WB register, store buffer with background drain to the
// L1 data cache, load forwarding from buffered stores, and event counters.
module mem_stage_sb
    import mem_stage_sb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int SB_DEPTH = SB_DEPTH_DEFAULT,
    parameter int CNT_W    = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic            reset_i,
    input  logic [XLEN-1:0] alu_mem_i,
    input  logic [XLEN-1:0] rs2_mem_i,
    input  logic [XLEN-1:0] pc4_mem_i,
    input  logic [XLEN-1:0] inst_mem_i,
    input  logic            MemRW_mem_i,
    input  logic            Valid_cpu2cache_mem_i,
    input  logic            stall_by_icache_i,
    input  logic [1:0]      WBSel_mem_i,
    input  logic            RegWEn_mem_i,
    input  logic [4:0]      rsW_mem_i,
    output logic            dc_req_valid_o,
    output logic            dc_req_rw_o,
    output logic [XLEN-1:0] dc_req_addr_o,
    output logic [XLEN-1:0] dc_req_data_o,
    input  logic            dc_resp_valid_i,
    input  logic [XLEN-1:0] dc_resp_data_i,
    output logic [XLEN-1:0] alu_wb_o,
    output logic [XLEN-1:0] pc4_wb_o,
    output logic [XLEN-1:0] mem_wb_o,
    output logic [XLEN-1:0] inst_wb_o,
    output logic [1:0]      WBSel_wb_o,
    output logic            RegWEn_wb_o,
    output logic [4:0]      rsW_wb_o,
    output logic            stall_by_dcache_o,
    output logic            sb_empty_o,
    output logic [CNT_W-1:0] no_ld_o,
    output logic [CNT_W-1:0] no_st_o,
    output logic [CNT_W-1:0] no_fwd_o,
    output logic [CNT_W-1:0] no_stall_o,
    output mem_fsm_e        dbg_state_o
);

    localparam int SBC_W = $clog2(SB_DEPTH) + 1;

    mem_fsm_e         state_q, state_d;
    logic             op, is_st, is_ld, sb_full, sb_push, sb_pop, sb_hit;
    logic             ld_hit, ld_miss, ld_resp, ld_done;
    logic [XLEN-1:0]  head_addr, head_data, hit_data, ld_addr_q;
    logic [SBC_W-1:0] sb_count;

    assign op      = Valid_cpu2cache_mem_i & ~stall_by_icache_i;
    assign is_st   = op & MemRW_mem_i;
    assign is_ld   = op & ~MemRW_mem_i;
    // A same-cycle pop is not counted as free space: fullness uses the current count.
    assign sb_full = (sb_count == SBC_W'(SB_DEPTH));
    assign sb_push = is_st & ~sb_full;
    assign sb_pop  = (state_q == MEM_DRAIN) & dc_resp_valid_i;
    assign ld_hit  = is_ld & sb_hit;
    assign ld_miss = is_ld & ~sb_hit;
    assign ld_resp = (state_q == MEM_LD_WAIT) & dc_resp_valid_i;
    assign ld_done = ld_hit | (ld_miss & ld_resp);

    assign stall_by_dcache_o = (is_st & sb_full) | (ld_miss & ~ld_resp);
    assign sb_empty_o        = (sb_count == '0);
    assign dbg_state_o       = state_q;

    mem_stage_sb_store_buffer #(.XLEN(XLEN), .SB_DEPTH(SB_DEPTH)) u_sb (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (sb_push),
        .push_addr_i  (alu_mem_i),
        .push_data_i  (rs2_mem_i),
        .pop_i        (sb_pop),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .lookup_addr_i(alu_mem_i),
        .hit_o        (sb_hit),
        .hit_data_o   (hit_data),
        .count_o      (sb_count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= MEM_IDLE;
        else         state_q <= state_d;
    end

    // Loads win over draining; an in-flight drain always runs to its response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MEM_IDLE: begin
                if (ld_miss)              state_d = MEM_LD_WAIT;
                else if (sb_count != '0)  state_d = MEM_DRAIN;
            end
            MEM_DRAIN:   if (dc_resp_valid_i) state_d = MEM_IDLE;
            MEM_LD_WAIT: if (dc_resp_valid_i) state_d = MEM_IDLE;
            default:     state_d = MEM_IDLE;
        endcase
    end

    always_comb begin
        dc_req_valid_o = 1'b0;
        dc_req_rw_o    = 1'b0;
        dc_req_addr_o  = '0;
        dc_req_data_o  = '0;
        unique case (state_q)
            MEM_DRAIN: begin
                dc_req_valid_o = 1'b1;
                dc_req_rw_o    = 1'b1;
                dc_req_addr_o  = head_addr;
                dc_req_data_o  = head_data;
            end
            MEM_LD_WAIT: begin
                dc_req_valid_o = 1'b1;
                dc_req_addr_o  = ld_addr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            ld_addr_q <= '0;
        else if ((state_q == MEM_IDLE) && (state_d == MEM_LD_WAIT))
            ld_addr_q <= alu_mem_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || (enable_i && reset_i)) begin
            alu_wb_o    <= '0;
            pc4_wb_o    <= '0;
            mem_wb_o    <= '0;
            inst_wb_o   <= '0;
            WBSel_wb_o  <= '0;
            RegWEn_wb_o <= 1'b0;
            rsW_wb_o    <= '0;
        end else if (enable_i) begin
            alu_wb_o    <= alu_mem_i;
            pc4_wb_o    <= pc4_mem_i;
            mem_wb_o    <= ld_hit ? hit_data : dc_resp_data_i;
            inst_wb_o   <= inst_mem_i;
            WBSel_wb_o  <= WBSel_mem_i;
            RegWEn_wb_o <= RegWEn_mem_i;
            rsW_wb_o    <= rsW_mem_i;
        end
    end

    // Counters saturate at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            no_ld_o    <= '0;
            no_st_o    <= '0;
            no_fwd_o   <= '0;
            no_stall_o <= '0;
        end else begin
            if (ld_done && !(&no_ld_o))              no_ld_o    <= no_ld_o + CNT_W'(1);
            if (sb_push && !(&no_st_o))              no_st_o    <= no_st_o + CNT_W'(1);
            if (ld_hit && !(&no_fwd_o))              no_fwd_o   <= no_fwd_o + CNT_W'(1);
            if (stall_by_dcache_o && !(&no_stall_o)) no_stall_o <= no_stall_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb: cache-side and load-result scoreboards
// fed by the stimulus tasks and checked by an independent monitor.
module tb_mem_stage_sb;
    import mem_stage_sb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, reset_i, enable;
    logic [31:0] alu, rs2, pc4, inst;
    logic        mem_rw, valid, stall_ic, reg_wen;
    logic [1:0]  wb_sel;
    logic [4:0]  rs_w;
    logic        dc_req_valid, dc_req_rw, dc_resp_valid;
    logic [31:0] dc_req_addr, dc_req_data, dc_resp_data;
    logic [31:0] alu_wb, pc4_wb, mem_wb, inst_wb;
    logic [1:0]  wb_sel_wb;
    logic        reg_wen_wb, stall_dc, sb_empty;
    logic [4:0]  rs_w_wb;
    logic [31:0] no_ld, no_st, no_fwd, no_stall;
    mem_fsm_e    dbg_state;

    int          total = 0;
    int          bad = 0;
    int          lat = 3;
    int          lat_cnt;
    int          waited;
    logic        ld_pend = 1'b0;
    logic [64:0] exp_q[$];
    logic [31:0] exp_ld_q[$];
    logic [64:0] exp_txn;

    always #5 clk = ~clk;
    assign enable = ~stall_dc;

    mem_stage_sb #(.XLEN(32), .SB_DEPTH(4), .CNT_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .reset_i(reset_i),
        .alu_mem_i(alu), .rs2_mem_i(rs2), .pc4_mem_i(pc4), .inst_mem_i(inst),
        .MemRW_mem_i(mem_rw), .Valid_cpu2cache_mem_i(valid),
        .stall_by_icache_i(stall_ic), .WBSel_mem_i(wb_sel),
        .RegWEn_mem_i(reg_wen), .rsW_mem_i(rs_w),
        .dc_req_valid_o(dc_req_valid), .dc_req_rw_o(dc_req_rw),
        .dc_req_addr_o(dc_req_addr), .dc_req_data_o(dc_req_data),
        .dc_resp_valid_i(dc_resp_valid), .dc_resp_data_i(dc_resp_data),
        .alu_wb_o(alu_wb), .pc4_wb_o(pc4_wb), .mem_wb_o(mem_wb), .inst_wb_o(inst_wb),
        .WBSel_wb_o(wb_sel_wb), .RegWEn_wb_o(reg_wen_wb), .rsW_wb_o(rs_w_wb),
        .stall_by_dcache_o(stall_dc), .sb_empty_o(sb_empty),
        .no_ld_o(no_ld), .no_st_o(no_st), .no_fwd_o(no_fwd), .no_stall_o(no_stall),
        .dbg_state_o(dbg_state)
    );

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Cache model: answers a request after lat cycles; loads return addr ^ 0xC0DE0000.
    initial begin
        dc_resp_valid = 1'b0;
        dc_resp_data  = '0;
        lat_cnt       = 0;
        forever begin
            @(posedge clk); #1;
            dc_resp_valid = 1'b0;
            if (dc_req_valid && rst_n) begin
                lat_cnt++;
                if (lat_cnt >= lat) begin
                    dc_resp_valid = 1'b1;
                    dc_resp_data  = dc_req_rw ? 32'h0 : (dc_req_addr ^ 32'hC0DE_0000);
                    lat_cnt       = 0;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Monitor: cache transactions in issue order, load results one cycle after completion.
    always @(negedge clk) begin
        if (!rst_n) begin
            ld_pend = 1'b0;
        end else begin
            if (ld_pend) begin
                if (exp_ld_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ld_result: got 0x%0h with no load expected", mem_wb);
                end else begin
                    check("ld_result", 65'(mem_wb), 65'(exp_ld_q.pop_front()));
                end
            end
            if (dc_req_valid && dc_resp_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cache_txn: got rw=%0b addr=0x%0h with none expected", dc_req_rw, dc_req_addr);
                end else begin
                    exp_txn = exp_q.pop_front();
                    check("cache_txn", {dc_req_rw, dc_req_addr, dc_req_data}, exp_txn);
                end
            end
            ld_pend = valid && !mem_rw && !stall_ic && !stall_dc;
        end
    end

    task automatic do_op(input logic st, input logic [31:0] addr, input logic [31:0] data,
                         input logic exp_read, input logic [31:0] exp_mem, output int n_wait);
        sb_entry_t ent;
        valid = 1'b1; mem_rw = st; alu = addr; rs2 = data; pc4 = addr + 32'd4;
        inst = st ? 32'h0000_2023 : 32'h0000_2003;
        reg_wen = ~st; wb_sel = st ? 2'd0 : 2'd1; rs_w = 5'd7;
        ent.addr = addr;
        ent.data = data;
        if (st) exp_q.push_back({1'b1, ent});
        else begin
            exp_ld_q.push_back(exp_mem);
            if (exp_read) exp_q.push_back({1'b0, addr, 32'h0});
        end
        n_wait = 0;
        @(negedge clk);
        while (stall_dc && n_wait < 300) begin
            n_wait++;
            @(negedge clk);
        end
        if (n_wait >= 300) begin
            total++; bad++;
            $display("FAIL op_timeout: addr 0x%0h still stalled after %0d cycles", addr, n_wait);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        valid = 1'b0;
        @(negedge clk);
        while (!(sb_empty && !dc_req_valid) && n < 300) begin
            n++;
            @(negedge clk);
        end
        check(name, 65'(sb_empty), 65'(1));
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        valid = 1'b0; rst_n = 1'b0;
        exp_q.delete();
        exp_ld_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; reset_i = 1'b0; valid = 1'b0; mem_rw = 1'b0; stall_ic = 1'b0;
        alu = '0; rs2 = '0; pc4 = '0; inst = '0; reg_wen = 1'b0; wb_sel = '0; rs_w = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_req_valid", 65'(dc_req_valid), 65'(0));
        check("rst_sb_empty", 65'(sb_empty), 65'(1));
        check("rst_mem_wb", 65'(mem_wb), 65'(0));
        check("rst_no_st", 65'(no_st), 65'(0));
        check("rst_state", 65'(dbg_state), 65'(MEM_IDLE));
        @(posedge clk); #1;

        // I-cache stall suppresses a store
        valid = 1'b1; mem_rw = 1'b1; alu = 32'h900; rs2 = 32'h99; stall_ic = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("icache_sb_empty", 65'(sb_empty), 65'(1));
        check("icache_no_st", 65'(no_st), 65'(0));
        @(posedge clk); #1;
        valid = 1'b0; stall_ic = 1'b0;

        // Three stores, latency 5: no stall, FIFO drain order
        lat = 5;
        do_op(1'b1, 32'h100, 32'h1111_0001, 1'b0, 32'h0, waited); check("t1_st0_wait", 65'(waited), 65'(0));
        do_op(1'b1, 32'h104, 32'h1111_0002, 1'b0, 32'h0, waited); check("t1_st1_wait", 65'(waited), 65'(0));
        do_op(1'b1, 32'h108, 32'h1111_0003, 1'b0, 32'h0, waited); check("t1_st2_wait", 65'(waited), 65'(0));
        wait_empty("t1_empty");
        check("t1_no_st", 65'(no_st), 65'(3));
        check("t1_no_stall", 65'(no_stall), 65'(0));

        // Forwarding from the youngest matching store
        apply_reset(); lat = 3;
        do_op(1'b1, 32'h200, 32'h0000_AAAA, 1'b0, 32'h0, waited);
        do_op(1'b1, 32'h200, 32'h0000_BBBB, 1'b0, 32'h0, waited);
        do_op(1'b0, 32'h200, 32'h0, 1'b0, 32'h0000_BBBB, waited);
        check("t2_ld_wait", 65'(waited), 65'(0));
        wait_empty("t2_empty");
        check("t2_no_fwd", 65'(no_fwd), 65'(1));
        check("t2_no_ld", 65'(no_ld), 65'(1));

        // Fifth back-to-back store stalls until the first drain pops
        apply_reset(); lat = 4;
        for (int i = 0; i < 4; i++) begin
            do_op(1'b1, 32'h600 + 32'(4 * i), 32'h5000 + 32'(i), 1'b0, 32'h0, waited);
            check("t3_st_wait", 65'(waited), 65'(0));
        end
        do_op(1'b1, 32'h610, 32'h5004, 1'b0, 32'h0, waited);
        check("t3_st4_wait", 65'(waited), 65'(2));
        wait_empty("t3_empty");
        check("t3_no_stall", 65'(no_stall), 65'(2));
        check("t3_no_st", 65'(no_st), 65'(5));

        // Missing load behind an in-flight drain
        apply_reset(); lat = 3;
        do_op(1'b1, 32'h10, 32'h1234, 1'b0, 32'h0, waited);
        idle(1);
        do_op(1'b0, 32'h300, 32'h0, 1'b1, 32'hC0DE_0300, waited);
        check("t4_ld_wait", 65'(waited), 65'(6));
        idle(2);
        check("t4_no_stall", 65'(no_stall), 65'(6));
        check("t4_no_ld", 65'(no_ld), 65'(1));
        check("t4_no_fwd", 65'(no_fwd), 65'(0));
        check("t4_state", 65'(dbg_state), 65'(MEM_IDLE));

        // rst_ni mid-drain with two entries buffered
        apply_reset(); lat = 5;
        do_op(1'b1, 32'h500, 32'h11, 1'b0, 32'h0, waited);
        do_op(1'b1, 32'h504, 32'h22, 1'b0, 32'h0, waited);
        valid = 1'b0;
        @(negedge clk);
        check("t5_pre_req_valid", 65'(dc_req_valid), 65'(1));
        check("t5_pre_sb_empty", 65'(sb_empty), 65'(0));
        @(posedge clk); #1;
        apply_reset();
        @(negedge clk);
        check("t5_req_valid", 65'(dc_req_valid), 65'(0));
        check("t5_sb_empty", 65'(sb_empty), 65'(1));
        check("t5_no_st", 65'(no_st), 65'(0));
        check("t5_state", 65'(dbg_state), 65'(MEM_IDLE));
        @(posedge clk); #1;
        idle(10);

        // Pipeline flush leaves buffered stores draining
        apply_reset(); lat = 3;
        do_op(1'b1, 32'h400, 32'h44, 1'b0, 32'h0, waited);
        do_op(1'b1, 32'h404, 32'h55, 1'b0, 32'h0, waited);
        valid = 1'b0; reset_i = 1'b1;
        alu = 32'hDEAD_BEEF; pc4 = 32'h1234_5678; inst = 32'h0000_0013;
        reg_wen = 1'b1; wb_sel = 2'd2; rs_w = 5'd9;
        @(negedge clk);
        check("t6_alu_wb_pre", 65'(alu_wb), 65'(32'h404));
        check("t6_pc4_wb_pre", 65'(pc4_wb), 65'(32'h408));
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("t6_wb_cleared", {alu_wb, pc4_wb, 1'b0}, 65'(0));
        check("t6_wb_ctrl", {inst_wb, wb_sel_wb, reg_wen_wb, rs_w_wb, 1'b0}, 65'(0));
        check("t6_mem_wb", 65'(mem_wb), 65'(0));
        @(posedge clk); #1;
        wait_empty("t6_empty");
        check("t6_no_st", 65'(no_st), 65'(2));

        idle(2);
        check("exp_q_drained", 65'(exp_q.size()), 65'(0));
        check("exp_ld_q_drained", 65'(exp_ld_q.size()), 65'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_sb.md
Name: mem_stage_sb

Overview:
Parametrised successor of the pipeline memory stage. It holds the MEM/WB pipeline register and talks to the L1 data cache over a valid/response handshake. New behaviour: an SB_DEPTH-entry store buffer retires stores without stalling, drains them to the cache in the background, and forwards buffered data to younger loads. It also keeps access, forward and stall counters.

Parameters:
XLEN, 32, data/address width
SB_DEPTH, 4, store-buffer entries (power of two, >=2)
CNT_W, 32, counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
enable_i  in  1  pipeline-register load enable
reset_i  in  1  pipeline flush (clears MEM/WB register only)
alu_mem_i  in  XLEN  effective address / ALU result
rs2_mem_i  in  XLEN  store data
pc4_mem_i  in  XLEN  PC+4
inst_mem_i  in  XLEN  instruction
MemRW_mem_i  in  1  1=store, 0=load
Valid_cpu2cache_mem_i  in  1  memory op present
stall_by_icache_i  in  1  suppresses new memory ops
WBSel_mem_i  in  2  writeback select
RegWEn_mem_i  in  1  register write enable
rsW_mem_i  in  5  destination register
dc_req_valid_o  out  1  cache request valid
dc_req_rw_o  out  1  cache request direction
dc_req_addr_o  out  XLEN  cache request address
dc_req_data_o  out  XLEN  cache store data
dc_resp_valid_i  in  1  cache done (one cycle)
dc_resp_data_i  in  XLEN  load data, valid with dc_resp_valid_i
alu_wb_o, pc4_wb_o, mem_wb_o, inst_wb_o  out  XLEN  registered to WB
WBSel_wb_o  out  2  registered to WB
RegWEn_wb_o  out  1  registered to WB
rsW_wb_o  out  5  registered to WB
stall_by_dcache_o  out  1  freeze earlier stages
sb_empty_o  out  1  buffer empty (for fences)
no_ld_o, no_st_o, no_fwd_o, no_stall_o  out  CNT_W  counters

Behaviour:
- op = Valid_cpu2cache_mem_i & ~stall_by_icache_i. Word accesses only. Address match compares bits [XLEN-1:2].
- Store (op & MemRW=1):
  - Buffer not full: enqueue {addr,data} at the tail this cycle, no stall.
  - Buffer full: stall_by_dcache_o=1 until count<SB_DEPTH.
  - A pop in the same cycle does not free a slot for that cycle's enqueue.
- Load (op & MemRW=0), buffer hit (any valid entry matches): data = youngest matching entry, combinational. Completes with no stall; no_fwd_o increments.
- Load, buffer miss: needs the cache. stall_by_dcache_o=1 until the cycle dc_resp_valid_i is seen in LD_WAIT. That cycle stall drops and dc_resp_data_i feeds mem_r directly.
- FSM states: IDLE, DRAIN, LD_WAIT.
  - IDLE -> LD_WAIT on a missing load. A load has priority over draining.
  - IDLE -> DRAIN when the buffer is non-empty and no missing load is present.
  - DRAIN -> IDLE on dc_resp_valid_i; the head entry pops.
  - LD_WAIT -> IDLE on dc_resp_valid_i.
  - A drain in flight is never cancelled. A missing load arriving during DRAIN waits for it.
- Request outputs:
  - dc_req_valid_o=1 exactly in DRAIN/LD_WAIT.
  - addr/rw/data are held stable from entry until the response.
  - In DRAIN, rw=1 and addr/data = head entry. In LD_WAIT, rw=0 and addr = alu_mem_i (stage frozen).
  - Idle values are all 0.
- Buffer pointers wrap modulo SB_DEPTH. count range 0..SB_DEPTH. sb_empty_o = (count==0).
- Pipeline register:
  - On enable_i & reset_i: all cleared.
  - On enable_i alone: captures inputs; mem_r captures forwarded data or dc_resp_data_i.
  - No enable: holds.
- Counters increment once per completed op, not per stalled cycle. no_stall_o increments per cycle with stall_by_dcache_o=1. All counters saturate at all-ones.
- reset_i does not touch the store buffer: buffered stores are architecturally committed.
- rst_ni=0 sampled at a clock edge:
  - Buffer emptied, FSM to IDLE, all outputs and counters 0, sb_empty_o=1.
  - Any in-flight cache transaction is abandoned; the cache shares rst_ni.
- A dc_resp_valid_i while IDLE is ignored.

Decomposition:
- cache_def package: add sb_entry_t {addr, data}, mem_fsm_e enum, SB_DEPTH default constant.
- Sub-module store_buffer: circular FIFO plus parallel address search with youngest-match priority. Ports: push, pop, head, lookup addr, hit, hit data, count.
- mem_stage_sb holds the FSM, the pipeline register and the counters.

Test Plan:
- Reset, then 3 stores to 0x100/0x104/0x108 with cache response latency 5 -> no stall; 3 drains in FIFO order; sb_empty_o=1 after ~18 cycles; no_st_o=3.
- Store 0xAAAA to 0x200, store 0xBBBB to 0x200, immediate load 0x200 -> mem_wb_o=0xBBBB; no cache read issued; no_fwd_o=1.
- 5 back-to-back stores, SB_DEPTH=4, latency 4 -> 5th store stalls until first drain pops; no_stall_o equals stalled cycles.
- Load 0x300 (miss in buffer) issued while a drain is in flight -> drain completes first; then LD_WAIT; stall drops on dc_resp_valid_i with mem_wb_o=dc_resp_data_i.
- rst_ni low mid-DRAIN with 2 entries -> next cycle dc_req_valid_o=0, sb_empty_o=1, counters 0.
- reset_i during buffered stores -> WB outputs 0; stores still drain.
